afifo_rd_packer: RTL and testbench
==================================

# afifo_rd_packer

Read-side consumer of the `afifo` clock-domain-crossing FIFO. It runs on the FIFO read clock and pops `C_WIDTH`-bit words through the FIFO's `i_ren`/`o_empty`/`o_rd_data` port. It packs `C_LANES` consecutive words into one wide beat and presents each beat on a valid/ready stream to the systolic-array row loader. Every `C_BEATS`-th beat is tagged with `o_last` to mark a tile boundary.

## Interface
- `C_WIDTH`, 32: FIFO word width in bits.
- `C_LANES`, 8: words per output beat; ≥2.
- `C_BEATS`, 4: beats per tile; ≥1; `o_last` period.
- `i_clk` in 1: single clock, the FIFO read clock.
- `i_rstn` in 1: reset, asynchronous and active-low.
- `o_ren` in FIFO terms, out 1: pop request; drives the FIFO `i_ren`.
- `i_empty` in 1: FIFO `o_empty`.
- `i_rd_data` in `C_WIDTH`: FIFO `o_rd_data`; valid exactly one cycle after `o_ren`.
- `o_valid` out 1: output beat valid.
- `i_ready` in 1: consumer ready.
- `o_data` out `C_WIDTH*C_LANES`: packed beat; lane k is `o_data[k*C_WIDTH +: C_WIDTH]`.
- `o_last` out 1: high with `o_valid` on the final beat of a tile.

## Operation
- State registers:
  - `lane_q` (0..`C_LANES`): words captured into the pack register.
  - `pend_q`: a pop was issued last cycle.
  - `pack_q`: pack register.
  - Output register: `o_data`/`o_valid`.
  - `beat_q` (0..`C_BEATS-1`).
- Capture: when `pend_q`=1, `i_rd_data` is written to lane `lane_q` and `lane_q` increments. The first popped word lands in lane 0.
- Transfer: `xfer = (lane_q==C_LANES) && (!o_valid || i_ready)`.
  - On `xfer`, `pack_q` is copied to `o_data`, `o_valid` is set, and `lane_q` is cleared to 0.
  - `pend_q` is 0 whenever `lane_q==C_LANES`.
- Pop rule (combinational): `o_ren = !i_empty && ((lane_q + pend_q) < C_LANES || xfer)`. The block never pops a word it has no lane for.
- Output handshake:
  - `o_valid && i_ready` with no `xfer` clears `o_valid`.
  - `o_valid && i_ready` together with `xfer` keeps `o_valid`=1 with the new data.
  - `o_data` and `o_last` are stable while `o_valid && !i_ready`.
- `beat_q` increments on each accepted beat and wraps from `C_BEATS-1` to 0. `o_last = o_valid && beat_q==C_BEATS-1`.
- Arithmetic:
  - `lane_q` width is `$clog2(C_LANES+1)`.
  - `beat_q` width is `$clog2(C_BEATS)`, minimum 1.
  - The `lane_q + pend_q` compare uses `lane_q` width + 1.
- Boundary conditions:
  - FIFO empty mid-beat: the partial pack is held indefinitely and no beat is emitted.
  - Consumer stall: the pack fills, then `o_ren` stays low until `xfer`.
  - `i_empty` rising in the same cycle a pop lands: the capture completes normally.
- Reset (async assert, sync deassert by the integrator):
  - Clears `lane_q`, `pend_q`, `beat_q` and `o_valid`.
  - `o_data` resets to 0, `o_ren`=0 (because `i_empty` gates it), `o_last`=0.
  - A pop in flight at reset is discarded. The FIFO read domain is reset together with this block.

## Timing
- `o_ren` is combinational from `i_empty`, `i_ready`, and registered state. There is no path from `i_rd_data`.
- Data capture happens one cycle after `o_ren`.
- Latency: first `o_ren` in cycle 0 with the FIFO never empty gives `o_valid` high in cycle `C_LANES+2`.
- Throughput: one beat per `C_LANES+1` cycles with `i_ready` held high. This includes one pop bubble per beat in the cycle where `lane_q+pend_q==C_LANES`.
- `o_data`, `o_valid` and `o_last` are registered outputs (`o_last` is decoded only from registers).

## Structure
- Package `afifo_pkg` holds:
  - Default `C_WIDTH`.
  - Typedef `word_t` (`logic [C_WIDTH-1:0]`).
  - Function `clog2_min1`, shared with `afifo`.
- Single module. Optional sub-module `wrap_counter` (parameterised modulus, increment enable, wrap flag) is used for `beat_q`. `lane_q` does not use it because of its distinct clear.

## Test plan
- FIFO preloaded with words 1..16, `i_ready`=1, `C_LANES`=8:
  - Beat 0 lanes = 1..8.
  - Beat 1 lanes = 9..16.
  - First `o_valid` 10 cycles after first `o_ren`; beats 9 cycles apart.
- `i_empty` toggled every other cycle while feeding 1..8 → one beat with lanes exactly 1..8; `o_ren` never high while `i_empty`=1.
- `i_ready`=0 with 24 words available:
  - One beat held stable.
  - Second pack fills to 8, then `o_ren` low.
  - Release `i_ready` → beats 1..8, 9..16, 17..24 in order with no loss.
- `C_BEATS`=4, 8 beats streamed → `o_last` high on beats 3 and 7 only.
- `i_rstn` pulsed low mid-pack (after 5 captures) → `o_valid`=0 and `o_data`=0 immediately. After release and refill from word 100, the next beat holds 100..107.
- `i_ready` toggling randomly over 64 words → output sequence equals input sequence. Scoreboard checks stability of `o_data` under stall.

Source files
------------

// File: rtl/afifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afifo_pkg
// Description : Shared types and helpers for the afifo CDC FIFO and its
//               read-side consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package afifo_pkg;

    // Default FIFO word width in bits.
    localparam int c_default_width = 32;

    typedef logic [c_default_width-1:0] word_t;

    // ceil(log2(n)), never less than 1, so a modulus-1 counter still has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Modulo-C_MOD counter with increment enable. o_wrap flags the
//               terminal count, decoded only from the count register.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter
    import afifo_pkg::*;
#(
    parameter int C_MOD = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    output logic o_wrap
);

    localparam int                  c_cnt_w = clog2_min1(C_MOD);
    localparam logic [c_cnt_w-1:0]  c_max   = c_cnt_w'(C_MOD - 1);

    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;

    // Next count: advance on enable, wrapping from the terminal value to 0.
    always_comb begin
        w_count_nxt = r_count;
        if (i_en) begin
            w_count_nxt = (r_count == c_max) ? '0 : r_count + c_cnt_w'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_wrap = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/afifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : afifo_rd_packer
// Description : Pops C_WIDTH-bit words from the afifo read port, packs
//               C_LANES of them into one wide beat and presents the beat on a
//               valid/ready stream. Every C_BEATS-th beat carries o_last.
// Revision    : 1.0 - initial release
// ============================================================================
module afifo_rd_packer
    import afifo_pkg::*;
#(
    parameter int C_WIDTH = c_default_width,
    parameter int C_LANES = 8,
    parameter int C_BEATS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    output logic                         o_ren,
    input  logic                         i_empty,
    input  logic [C_WIDTH-1:0]           i_rd_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [C_WIDTH*C_LANES-1:0]   o_data,
    output logic                         o_last
);

    localparam int                   c_lane_w = $clog2(C_LANES + 1);
    localparam int                   c_idx_w  = clog2_min1(C_LANES);
    localparam logic [c_lane_w-1:0]  c_full   = c_lane_w'(C_LANES);
    localparam logic [c_lane_w:0]    c_cmp    = (c_lane_w + 1)'(C_LANES);

    logic [c_lane_w-1:0]               r_lane;
    logic [c_lane_w-1:0]               w_lane_nxt;
    logic                              r_pend;
    logic [C_LANES-1:0][C_WIDTH-1:0]   r_pack;
    logic [C_LANES-1:0][C_WIDTH-1:0]   w_pack_nxt;
    logic [C_WIDTH*C_LANES-1:0]        r_data;
    logic [C_WIDTH*C_LANES-1:0]        w_data_nxt;
    logic                              r_valid;
    logic                              w_valid_nxt;

    logic                              w_full;
    logic                              w_xfer;
    logic                              w_accept;
    logic                              w_room;
    logic [c_lane_w:0]                 w_inflight;
    logic [c_idx_w-1:0]                w_lane_idx;
    logic                              w_beat_wrap;

    // A pending pop only exists while a lane is free, so r_lane < C_LANES
    // whenever the index is used and the narrower slice is exact.
    assign w_lane_idx = r_lane[c_idx_w-1:0];

    // Words captured plus the word still in flight, one bit wider to hold C_LANES+1.
    assign w_inflight = {1'b0, r_lane} + {{c_lane_w{1'b0}}, r_pend};
    assign w_room     = (w_inflight < c_cmp);
    assign w_full     = (r_lane == c_full);
    assign w_xfer     = w_full && (!r_valid || i_ready);
    assign w_accept   = r_valid && i_ready;

    // Pop only when a lane is guaranteed for the word; no path from i_rd_data.
    assign o_ren = !i_empty && (w_room || w_xfer);

    // Pack and output register next-state.
    always_comb begin
        w_lane_nxt  = r_lane;
        w_pack_nxt  = r_pack;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        if (w_xfer) begin
            w_lane_nxt  = '0;
            w_data_nxt  = r_pack;
            w_valid_nxt = 1'b1;
        end else begin
            if (r_pend) begin
                w_pack_nxt[w_lane_idx] = i_rd_data;
                w_lane_nxt             = r_lane + c_lane_w'(1);
            end
            if (w_accept) begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    // State registers; a pop in flight at reset is dropped with r_pend.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_lane  <= '0;
            r_pend  <= 1'b0;
            r_pack  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_lane  <= w_lane_nxt;
            r_pend  <= o_ren;
            r_pack  <= w_pack_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Tile position: counts accepted beats, flags the final beat of a tile.
    wrap_counter #(
        .C_MOD (C_BEATS)
    ) u_beat_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_en   (w_accept),
        .o_wrap (w_beat_wrap)
    );

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_valid && w_beat_wrap;

endmodule
`default_nettype wire

// File: tb/tb_afifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_afifo_rd_packer
// Description : Directed, table-driven bench for afifo_rd_packer with a
//               small behavioural FIFO read port and a beat monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afifo_rd_packer;

    localparam int c_w     = 32;
    localparam int c_lanes = 8;
    localparam int c_beats = 4;
    localparam int c_dw    = c_w * c_lanes;

    typedef struct {
        int base;
        int nwords;
        int empty_mode;
        int ready_mode;
        int exp_beats;
        int last_mask;
    } vec_t;

    typedef struct {
        logic [c_dw-1:0] data;
        logic            last;
        int              cyc;
    } beat_t;

    logic            clk;
    logic            rstn;
    logic            o_ren;
    logic            i_empty;
    logic [c_w-1:0]  rd_data;
    logic            o_valid;
    logic            i_ready;
    logic [c_dw-1:0] o_data;
    logic            o_last;

    logic [c_w-1:0]  mem [0:127];
    int              rd_ptr;
    int              avail;
    logic            force_empty;
    int              empty_mode;
    int              ready_mode;
    logic            stall_rel;

    int              checks;
    int              failures;
    int              cyc;
    int              first_ren;
    int              first_valid;
    beat_t           acc [$];
    logic            prev_stall;
    logic [c_dw-1:0] prev_data;
    logic            prev_last;
    vec_t            vecs [5];

    afifo_rd_packer #(
        .C_WIDTH (c_w),
        .C_LANES (c_lanes),
        .C_BEATS (c_beats)
    ) u_dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .o_ren     (o_ren),
        .i_empty   (i_empty),
        .i_rd_data (rd_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_last    (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO read port model: reset with the packer, data one cycle after pop.
    assign i_empty = !rstn || (rd_ptr >= avail) || force_empty;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr  <= 0;
            rd_data <= '0;
        end else if (o_ren) begin
            rd_data <= mem[rd_ptr & 127];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Input drivers, changed away from the active edge.
    always @(negedge clk) begin
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = stall_rel;
        endcase
        if (empty_mode != 0) force_empty = !force_empty;
        else                 force_empty = 1'b0;
    end

    task automatic check(input string name, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [c_dw-1:0] exp_beat(input int base, input int b);
        logic [c_dw-1:0] r;
        r = '0;
        for (int k = 0; k < c_lanes; k++) r[k*c_w +: c_w] = c_w'(base + b * c_lanes + k);
        return r;
    endfunction

    // Monitor: pop legality, stall stability, latency marks, accepted beats.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rstn) begin
            if (i_empty) check("ren_while_empty", c_dw'(o_ren), c_dw'(0));
            if (prev_stall) begin
                check("stall_valid", c_dw'(o_valid), c_dw'(1));
                check("stall_data", o_data, prev_data);
                check("stall_last", c_dw'(o_last), c_dw'(prev_last));
            end
            if (o_ren && first_ren < 0)     first_ren = cyc;
            if (o_valid && first_valid < 0) first_valid = cyc;
            if (o_valid && i_ready) acc.push_back('{o_data, o_last, cyc});
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_run(input int base, input int nwords);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 128; j++) mem[j] = c_w'(base + j);
        avail       = nwords;
        acc.delete();
        first_ren   = -1;
        first_valid = -1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (acc.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("beat_timeout", c_dw'(acc.size()), c_dw'(n));
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v          = vecs[idx];
        empty_mode = v.empty_mode;
        ready_mode = v.ready_mode;
        stall_rel  = 1'b0;
        start_run(v.base, v.nwords);
        if (v.ready_mode == 2) begin
            repeat (40) @(negedge clk);
            check("stall_hold_valid", c_dw'(o_valid), c_dw'(1));
            check("stall_no_pop", c_dw'(o_ren), c_dw'(0));
            check("stall_popped", c_dw'(rd_ptr), c_dw'(16));
            check("stall_head_data", o_data, exp_beat(v.base, 0));
            check("stall_no_accept", c_dw'(acc.size()), c_dw'(0));
            stall_rel = 1'b1;
        end
        wait_beats(v.exp_beats);
        repeat (20) @(negedge clk);
        check("beat_count", c_dw'(acc.size()), c_dw'(v.exp_beats));
        for (int b = 0; b < v.exp_beats && b < acc.size(); b++) begin
            check("beat_data", acc[b].data, exp_beat(v.base, b));
            check("beat_last", c_dw'(acc[b].last), c_dw'((v.last_mask >> b) & 1));
        end
        if (idx == 0 && acc.size() >= 2) begin
            check("first_latency", c_dw'(first_valid - first_ren), c_dw'(10));
            check("beat_spacing", c_dw'(acc[1].cyc - acc[0].cyc), c_dw'(9));
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        first_ren   = -1;
        first_valid = -1;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;
        rstn        = 1'b0;
        i_ready     = 1'b0;
        force_empty = 1'b0;
        empty_mode  = 0;
        ready_mode  = 0;
        stall_rel   = 1'b0;
        avail       = 0;
        for (int j = 0; j < 128; j++) mem[j] = '0;

        //            base nwords empty ready beats last_mask
        vecs[0] = '{  1,   16,    0,    0,    2,    'h00};
        vecs[1] = '{  1,    8,    1,    0,    1,    'h00};
        vecs[2] = '{  1,   24,    0,    2,    3,    'h00};
        vecs[3] = '{  1,   64,    0,    0,    8,    'h88};
        vecs[4] = '{200,   64,    0,    1,    8,    'h88};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_valid", c_dw'(o_valid), c_dw'(0));
        check("reset_data", o_data, '0);
        check("reset_last", c_dw'(o_last), c_dw'(0));
        check("reset_ren", c_dw'(o_ren), c_dw'(0));

        for (int i = 0; i < 5; i++) run_vec(i);

        // Reset mid-pack while a stalled beat is held.
        empty_mode = 0;
        ready_mode = 2;
        stall_rel  = 1'b0;
        start_run(500, 16);
        repeat (15) @(posedge clk);
        #1;
        check("prereset_valid", c_dw'(o_valid), c_dw'(1));
        check("prereset_data", o_data, exp_beat(500, 0));
        rstn = 1'b0;
        #1;
        check("midreset_valid", c_dw'(o_valid), c_dw'(0));
        check("midreset_data", o_data, '0);
        check("midreset_last", c_dw'(o_last), c_dw'(0));
        check("midreset_ren", c_dw'(o_ren), c_dw'(0));
        stall_rel = 1'b1;
        start_run(100, 8);
        wait_beats(1);
        repeat (20) @(negedge clk);
        check("post_reset_count", c_dw'(acc.size()), c_dw'(1));
        if (acc.size() >= 1) begin
            check("post_reset_data", acc[0].data, exp_beat(100, 0));
            check("post_reset_last", c_dw'(acc[0].last), c_dw'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
